// File: rtl/avalon_arb2.sv
// avalon_arb2 - two-host to one-agent Avalon-MM arbiter.
//
// Lets two requesters (for example a CPU port and a DMA port) share one
// avalon_bram agent. Grants are round-robin. The owning host's transfer is
// forwarded to the agent, and the read response is steered back to that
// owner. A timeout counter guards every read, so a silent agent cannot lock
// the bus.
//
// Ports
//   clk, reset           single clock; synchronous active-high reset
//   h0_* / h1_*          host-side Avalon-MM agent ports
//                        address, read, write, writedata and byteenable are inputs;
//                        waitrequest, readdata, readdatavalid and rd_error are outputs
//   a_*                  agent-side Avalon-MM host port
//                        address, read, write, writedata and byteenable are outputs;
//                        waitrequest, readdata and readdatavalid are inputs
//   hX_rd_error          pulses together with hX_readdatavalid when a read timed out

module avalon_arb2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 16,
  parameter logic [DATA_W-1:0] ERR_WORD = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   h0_address,
  input  logic                h0_read,
  input  logic                h0_write,
  input  logic [DATA_W-1:0]   h0_writedata,
  input  logic [DATA_W/8-1:0] h0_byteenable,
  output logic                h0_waitrequest,
  output logic [DATA_W-1:0]   h0_readdata,
  output logic                h0_readdatavalid,
  output logic                h0_rd_error,

  input  logic [ADDR_W-1:0]   h1_address,
  input  logic                h1_read,
  input  logic                h1_write,
  input  logic [DATA_W-1:0]   h1_writedata,
  input  logic [DATA_W/8-1:0] h1_byteenable,
  output logic                h1_waitrequest,
  output logic [DATA_W-1:0]   h1_readdata,
  output logic                h1_readdatavalid,
  output logic                h1_rd_error,

  output logic [ADDR_W-1:0]   a_address,
  output logic                a_read,
  output logic                a_write,
  output logic [DATA_W-1:0]   a_writedata,
  output logic [DATA_W/8-1:0] a_byteenable,
  input  logic                a_waitrequest,
  input  logic [DATA_W-1:0]   a_readdata,
  input  logic                a_readdatavalid
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, XFER, RD_WAIT} state_t;

  state_t           state;
  logic             owner;
  logic             last;
  logic [CNT_W-1:0] tmo_cnt;

  logic req0, req1, grant;
  logic own_read, own_write, own_req;
  logic tmo_hit;
  logic             rsp_valid;
  logic             rsp_err;
  logic [DATA_W-1:0] rsp_data;

  assign req0 = h0_read | h0_write;
  assign req1 = h1_read | h1_write;

  // On a tie, the host that did not win last time gets the grant.
  // A lone requester wins outright.
  assign grant = (req0 && req1) ? ~last : req1;

  assign own_read  = owner ? h1_read  : h0_read;
  assign own_write = owner ? h1_write : h0_write;
  assign own_req   = own_read | own_write;
  assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Agent-side mux and host-side response steering.
  // Everything defaults to the idle values, so only XFER drives the agent.
  // Only RD_WAIT can produce a response, and it goes to the owner alone.
  always_comb begin
    a_address        = '0;
    a_read           = 1'b0;
    a_write          = 1'b0;
    a_writedata      = '0;
    a_byteenable     = '0;
    h0_waitrequest   = 1'b1;
    h1_waitrequest   = 1'b1;
    rsp_valid        = 1'b0;
    rsp_err          = 1'b0;
    rsp_data         = '0;
    h0_readdatavalid = 1'b0;
    h0_readdata      = '0;
    h0_rd_error      = 1'b0;
    h1_readdatavalid = 1'b0;
    h1_readdata      = '0;
    h1_rd_error      = 1'b0;

    case (state)
      XFER: begin
        a_address    = owner ? h1_address    : h0_address;
        a_read       = own_read;
        a_write      = own_write;
        a_writedata  = owner ? h1_writedata  : h0_writedata;
        a_byteenable = owner ? h1_byteenable : h0_byteenable;
        if (owner) h1_waitrequest = a_waitrequest;
        else       h0_waitrequest = a_waitrequest;
      end
      RD_WAIT: begin
        // A real agent response takes priority over a timeout in the same cycle.
        if (a_readdatavalid) begin
          rsp_valid = 1'b1;
          rsp_data  = a_readdata;
        end else if (tmo_hit) begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
          rsp_data  = ERR_WORD;
        end
      end
      default: ;
    endcase

    if (owner) begin
      h1_readdatavalid = rsp_valid;
      h1_readdata      = rsp_data;
      h1_rd_error      = rsp_err;
    end else begin
      h0_readdatavalid = rsp_valid;
      h0_readdata      = rsp_data;
      h0_rd_error      = rsp_err;
    end
  end

  // Arbitration FSM.
  // tmo_cnt is zero outside RD_WAIT. It stops at TIMEOUT-1 because the FSM
  // always leaves RD_WAIT on that cycle, so the counter never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (req0 || req1) begin
            owner <= grant;
            last  <= grant;
            state <= XFER;
          end
        end
        XFER: begin
          tmo_cnt <= '0;
          if (!own_req) state <= IDLE;
          else if (!a_waitrequest) state <= own_read ? RD_WAIT : IDLE;
        end
        RD_WAIT: begin
          if (a_readdatavalid || tmo_hit) begin
            state   <= IDLE;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tmo_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_arb2.sv
// tb_avalon_arb2 - self-checking bench for avalon_arb2.
// A small zero-wait-state BRAM model acts as the agent. Table vectors run
// single transfers; hand-written sequences cover contention, timeout and
// reset in the middle of a read.

module tb_avalon_arb2;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;

  logic [31:0] h0_address, h1_address;
  logic        h0_read, h1_read, h0_write, h1_write;
  logic [31:0] h0_writedata, h1_writedata;
  logic [3:0]  h0_byteenable, h1_byteenable;
  logic        h0_waitrequest, h1_waitrequest;
  logic [31:0] h0_readdata, h1_readdata;
  logic        h0_readdatavalid, h1_readdatavalid;
  logic        h0_rd_error, h1_rd_error;

  logic [31:0] a_address;
  logic        a_read, a_write;
  logic [31:0] a_writedata;
  logic [3:0]  a_byteenable;
  logic        a_waitrequest;
  logic [31:0] a_readdata;
  logic        a_readdatavalid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  avalon_arb2 #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .ERR_WORD(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset(reset),
    .h0_address(h0_address), .h0_read(h0_read), .h0_write(h0_write),
    .h0_writedata(h0_writedata), .h0_byteenable(h0_byteenable),
    .h0_waitrequest(h0_waitrequest), .h0_readdata(h0_readdata),
    .h0_readdatavalid(h0_readdatavalid), .h0_rd_error(h0_rd_error),
    .h1_address(h1_address), .h1_read(h1_read), .h1_write(h1_write),
    .h1_writedata(h1_writedata), .h1_byteenable(h1_byteenable),
    .h1_waitrequest(h1_waitrequest), .h1_readdata(h1_readdata),
    .h1_readdatavalid(h1_readdatavalid), .h1_rd_error(h1_rd_error),
    .a_address(a_address), .a_read(a_read), .a_write(a_write),
    .a_writedata(a_writedata), .a_byteenable(a_byteenable),
    .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid)
  );

  // Agent model: 16-word BRAM with no wait states and one cycle of read latency.
  // 'silent' suppresses responses, and 'inj_rv' injects a stray valid.
  logic [31:0] mem [0:15];
  logic        silent = 1'b0;
  logic        inj_rv = 1'b0;
  logic        mdl_rv = 1'b0;
  logic [31:0] mdl_rd = '0;

  assign a_waitrequest   = 1'b0;
  assign a_readdatavalid = mdl_rv | inj_rv;
  assign a_readdata      = mdl_rd;

  always @(posedge clk) begin
    mdl_rv <= (a_read === 1'b1) && !silent;
    if (a_read === 1'b1) mdl_rd <= mem[a_address[3:0]];
    if (a_write === 1'b1)
      for (int b = 0; b < 4; b++)
        if (a_byteenable[b]) mem[a_address[3:0]][8*b +: 8] <= a_writedata[8*b +: 8];
  end

  typedef struct {
    int          host;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [0:11];
  int   grant_seq [0:7];
  int   gidx = 0;
  bit   wr_overlap = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setHost(input int h, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    if (h == 0) begin
      h0_read = rd; h0_write = wr; h0_address = addr; h0_writedata = data; h0_byteenable = be;
    end else begin
      h1_read = rd; h1_write = wr; h1_address = addr; h1_writedata = data; h1_byteenable = be;
    end
  endtask

  function automatic logic hostWait(input int h);
    return (h == 0) ? h0_waitrequest : h1_waitrequest;
  endfunction
  function automatic logic hostRdv(input int h);
    return (h == 0) ? h0_readdatavalid : h1_readdatavalid;
  endfunction
  function automatic logic [31:0] hostRdata(input int h);
    return (h == 0) ? h0_readdata : h1_readdata;
  endfunction
  function automatic logic hostErr(input int h);
    return (h == 0) ? h0_rd_error : h1_rd_error;
  endfunction
  function automatic logic otherBusy(input int h);
    return (h == 0) ? (h1_readdatavalid | h1_rd_error | (|h1_readdata))
                    : (h0_readdatavalid | h0_rd_error | (|h0_readdata));
  endfunction

  // Runs one single-host transfer.
  // The task is entered and left 1 time unit after a rising edge.
  task automatic applyStimulus(input vec_t v, input string name);
    int   n;
    logic other;
    other = 1'b0;
    setHost(v.host, !v.wr, v.wr, v.addr, v.data, v.be);
    n = 0;
    do begin
      @(negedge clk); n++;
      other |= otherBusy(v.host);
    end while (hostWait(v.host) !== 1'b0 && n < 20);
    checkOutput({name, " grant latency"}, n, 2);
    checkOutput({name, " a_address"}, a_address, v.addr);
    checkOutput({name, " a_write"}, a_write, v.wr);
    checkOutput({name, " a_read"}, a_read, !v.wr);
    @(posedge clk); #1;
    setHost(v.host, 0, 0, 0, 0, 0);
    if (!v.wr) begin
      n = 0;
      do begin
        @(negedge clk); n++;
        other |= otherBusy(v.host);
      end while (hostRdv(v.host) !== 1'b1 && n < TIMEOUT + 4);
      checkOutput({name, " readdatavalid"}, hostRdv(v.host), 1'b1);
      checkOutput({name, " readdata"}, hostRdata(v.host), v.exp_data);
      checkOutput({name, " rd_error"}, hostErr(v.host), v.exp_err);
      checkOutput({name, " read latency"}, n, v.exp_lat);
      @(posedge clk); #1;
    end
    checkOutput({name, " non-owner quiet"}, other, 1'b0);
  endtask

  // One host of the contention test: four back-to-back writes.
  // Each grant is logged in the order it occurs.
  task automatic hostWriter(input int h);
    int n;
    for (int i = 0; i < 4; i++) begin
      setHost(h, 0, 1, (h == 0) ? 32'(i) : 32'(8 + i),
              (h == 0) ? 32'hA000_0000 + 32'(i) : 32'hB000_0000 + 32'(i), 4'hF);
      n = 0;
      do begin
        @(negedge clk); n++;
        if (h0_waitrequest === 1'b0 && h1_waitrequest === 1'b0) wr_overlap = 1;
      end while (hostWait(h) !== 1'b0 && n < 40);
      checkOutput($sformatf("contention h%0d write %0d granted", h, i), hostWait(h), 1'b0);
      if (gidx < 8) grant_seq[gidx] = h;
      gidx++;
      @(posedge clk); #1;
    end
    setHost(h, 0, 0, 0, 0, 0);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{0, 1, 32'd5,  32'h1234_5678, 4'hF,    32'h0,         1'b0, 1};
    vecs[1]  = '{0, 0, 32'd5,  32'h0,         4'h0,    32'h1234_5678, 1'b0, 1};
    vecs[2]  = '{1, 1, 32'd5,  32'hAABB_CCDD, 4'b0101, 32'h0,         1'b0, 1};
    vecs[3]  = '{0, 0, 32'd5,  32'h0,         4'h0,    32'h12BB_56DD, 1'b0, 1};
    vecs[4]  = '{0, 0, 32'd0,  32'h0,         4'h0,    32'hA000_0000, 1'b0, 1};
    vecs[5]  = '{0, 0, 32'd1,  32'h0,         4'h0,    32'hA000_0001, 1'b0, 1};
    vecs[6]  = '{0, 0, 32'd2,  32'h0,         4'h0,    32'hA000_0002, 1'b0, 1};
    vecs[7]  = '{0, 0, 32'd3,  32'h0,         4'h0,    32'hA000_0003, 1'b0, 1};
    vecs[8]  = '{1, 0, 32'd8,  32'h0,         4'h0,    32'hB000_0000, 1'b0, 1};
    vecs[9]  = '{1, 0, 32'd9,  32'h0,         4'h0,    32'hB000_0001, 1'b0, 1};
    vecs[10] = '{1, 0, 32'd10, 32'h0,         4'h0,    32'hB000_0002, 1'b0, 1};
    vecs[11] = '{1, 0, 32'd11, 32'h0,         4'h0,    32'hB000_0003, 1'b0, 1};

    setHost(0, 0, 0, 0, 0, 0);
    setHost(1, 0, 0, 0, 0, 0);

    // Reset hold, then release with no requests pending.
    reset = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b0;
      checkOutput($sformatf("idle %0d waitrequests", i), {h0_waitrequest, h1_waitrequest}, 2'b11);
      checkOutput($sformatf("idle %0d agent strobes", i), {a_read, a_write}, 2'b00);
      checkOutput($sformatf("idle %0d readdatavalid", i), {h0_readdatavalid, h1_readdatavalid}, 2'b00);
      checkOutput($sformatf("idle %0d h0_readdata", i), h0_readdata, 32'h0);
    end
    @(posedge clk); #1;

    // Write, read, byte-enable merge, readback.
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Contention: a fresh reset makes host0 win the first tie.
    resetDut();
    fork
      hostWriter(0);
      hostWriter(1);
    join
    checkOutput("contention grant count", gidx, 8);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("contention grant %0d", k), grant_seq[k], k % 2);
    checkOutput("contention waitrequest exclusive", wr_overlap, 1'b0);
    for (int i = 4; i < 12; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Timeout on an h1 read. Then a late agent valid, then a normal h0 read.
    silent = 1'b1;
    applyStimulus('{1, 0, 32'd0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, TIMEOUT}, "timeout");
    silent = 1'b0;
    inj_rv = 1'b1;
    @(negedge clk);
    checkOutput("late valid dropped", {h0_readdatavalid, h1_readdatavalid}, 2'b00);
    @(posedge clk); #1;
    inj_rv = 1'b0;
    applyStimulus('{0, 0, 32'd5, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0, 1}, "post-timeout read");

    // Reset while in RD_WAIT. The agent answers two cycles after reset rises.
    begin
      int  n;
      logic seen;
      silent = 1'b1;
      setHost(1, 1, 0, 32'd1, 0, 0);
      n = 0;
      do begin @(negedge clk); n++; end while (h1_waitrequest !== 1'b0 && n < 20);
      checkOutput("midreset read granted", h1_waitrequest, 1'b0);
      @(posedge clk); #1;
      setHost(1, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      seen = 1'b0;
      @(negedge clk);
      seen |= h0_readdatavalid | h1_readdatavalid;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      seen |= h0_readdatavalid | h1_readdatavalid;
      @(posedge clk); #1;
      inj_rv = 1'b1;
      @(negedge clk);
      seen |= h0_readdatavalid | h1_readdatavalid;
      checkOutput("midreset idle waitrequests", {h0_waitrequest, h1_waitrequest}, 2'b11);
      checkOutput("midreset idle a_read", a_read, 1'b0);
      @(posedge clk); #1;
      inj_rv = 1'b0;
      silent = 1'b0;
      checkOutput("midreset no readdatavalid", seen, 1'b0);

      // Both hosts request at once. After reset, host0 must win.
      setHost(0, 0, 1, 32'd6, 32'h0000_0066, 4'hF);
      setHost(1, 0, 1, 32'd7, 32'h0000_0077, 4'hF);
      @(negedge clk);
      @(negedge clk);
      checkOutput("post-reset grant h0", {h0_waitrequest, h1_waitrequest}, 2'b01);
      @(posedge clk); #1;
      setHost(0, 0, 0, 0, 0, 0);
      n = 0;
      do begin @(negedge clk); n++; end while (h1_waitrequest !== 1'b0 && n < 20);
      checkOutput("post-reset h1 follows", h1_waitrequest, 1'b0);
      @(posedge clk); #1;
      setHost(1, 0, 0, 0, 0, 0);
    end
    applyStimulus('{1, 0, 32'd6, 32'h0, 4'h0, 32'h0000_0066, 1'b0, 1}, "readback 6");
    applyStimulus('{0, 0, 32'd7, 32'h0, 4'h0, 32'h0000_0077, 1'b0, 1}, "readback 7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
